// File: rtl/poly_align.sv
// rtl/poly_align.sv - shifts a GF(2^12) polynomial up so its leading term lands at a target degree
module poly_align #(
  parameter int COEF_W   = 12,
  parameter int NUM_COEF = 12,
  parameter int DAT_W    = COEF_W * NUM_COEF,
  parameter int DEG_W    = 4
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               start,
  input  logic [0:DAT_W-1]   poly_in,
  input  logic [DEG_W-1:0]   poly_deg_in,
  input  logic [DEG_W-1:0]   target_deg,
  output logic               busy,
  output logic               align_done,
  output logic               align_err,
  output logic [0:DAT_W-1]   poly_out,
  output logic [COEF_W-1:0]  lead_coef_out,
  output logic [DEG_W-1:0]   shift_amt_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [DEG_W-1:0] MAX_DEG = DEG_W'(NUM_COEF - 1);

  state_t            state;
  state_t            state_nx;
  logic [DEG_W-1:0]  cnt;
  logic [DEG_W-1:0]  diff;
  logic              req_err;
  logic              accept;
  logic [COEF_W-1:0] lead_sel;
  logic [COEF_W-1:0] coef [NUM_COEF];

  assign accept  = (state == IDLE) && start;
  assign diff    = target_deg - poly_deg_in;
  assign req_err = (poly_deg_in > target_deg) || (target_deg > MAX_DEG);
  assign busy    = (state != IDLE);

  // Degrees beyond the last slot have no coefficient and report zero.
  always_comb begin
    lead_sel = '0;
    for (int i = 0; i < NUM_COEF; i++) begin
      if (poly_deg_in == DEG_W'(i)) begin
        lead_sel = poly_in[i*COEF_W +: COEF_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (req_err || (diff == '0)) begin
            state_nx = DONE;
          end else begin
            state_nx = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (cnt == DEG_W'(1)) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The working register doubles as poly_out; it only moves while busy.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        coef[i] <= '0;
      end
      cnt           <= '0;
      align_done    <= 1'b0;
      align_err     <= 1'b0;
      lead_coef_out <= '0;
      shift_amt_out <= '0;
    end else begin
      align_done <= (state == DONE);
      if (accept) begin
        for (int i = 0; i < NUM_COEF; i++) begin
          coef[i] <= poly_in[i*COEF_W +: COEF_W];
        end
        cnt           <= req_err ? '0 : diff;
        shift_amt_out <= req_err ? '0 : diff;
        align_err     <= req_err;
        lead_coef_out <= lead_sel;
      end else if (state == SHIFT) begin
        for (int i = NUM_COEF - 1; i > 0; i--) begin
          coef[i] <= coef[i-1];
        end
        coef[0] <= '0;
        cnt     <= cnt - DEG_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_COEF; g++) begin : g_out
    assign poly_out[g*COEF_W +: COEF_W] = coef[g];
  end

endmodule

// File: tb/tb_poly_align.sv
// tb/tb_poly_align.sv - randomized bench for poly_align with a per-cycle reference model
module tb_poly_align;

  localparam int COEF_W   = 12;
  localparam int NUM_COEF = 12;
  localparam int DAT_W    = COEF_W * NUM_COEF;
  localparam int DEG_W    = 4;

  logic               clk = 1'b0;
  logic               rst_b = 1'b0;
  logic               start = 1'b0;
  logic [0:DAT_W-1]   poly_in = '0;
  logic [DEG_W-1:0]   poly_deg_in = '0;
  logic [DEG_W-1:0]   target_deg = '0;
  logic               busy;
  logic               align_done;
  logic               align_err;
  logic [0:DAT_W-1]   poly_out;
  logic [COEF_W-1:0]  lead_coef_out;
  logic [DEG_W-1:0]   shift_amt_out;

  int checks = 0;
  int failures = 0;

  logic [COEF_W-1:0] req_c [NUM_COEF];

  poly_align #(
    .COEF_W(COEF_W), .NUM_COEF(NUM_COEF), .DAT_W(DAT_W), .DEG_W(DEG_W)
  ) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .poly_in(poly_in),
    .poly_deg_in(poly_deg_in), .target_deg(target_deg), .busy(busy),
    .align_done(align_done), .align_err(align_err), .poly_out(poly_out),
    .lead_coef_out(lead_coef_out), .shift_amt_out(shift_amt_out)
  );

  always #5 clk = ~clk;

  function automatic logic [COEF_W-1:0] get_coef(input logic [0:DAT_W-1] p, input int i);
    return p[i*COEF_W +: COEF_W];
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: tracks the expected result of each accepted request in
  // terms of whole coefficients, and checks handshake and held outputs every cycle.
  initial begin : model
    int cyc, next_ok, done_edge, d, lat;
    bit pending, exp_busy, exp_done, err;
    logic s_rst, s_start;
    logic [0:DAT_W-1] s_poly;
    int s_deg, s_tgt;
    logic [COEF_W-1:0] in_c [NUM_COEF];
    logic [COEF_W-1:0] exp_c [NUM_COEF];
    logic [COEF_W-1:0] exp_lead;
    int exp_shift;
    bit exp_err;
    cyc = 0; next_ok = 0; done_edge = 0; pending = 0;
    exp_lead = '0; exp_shift = 0; exp_err = 0;
    for (int i = 0; i < NUM_COEF; i++) exp_c[i] = '0;
    forever begin
      @(posedge clk);
      s_rst = rst_b; s_start = start; s_poly = poly_in;
      s_deg = int'(poly_deg_in); s_tgt = int'(target_deg);
      #1;
      if (!s_rst || !rst_b) begin
        pending = 0; next_ok = 0;
        exp_lead = '0; exp_shift = 0; exp_err = 0;
        for (int i = 0; i < NUM_COEF; i++) exp_c[i] = '0;
      end else if (s_start && cyc >= next_ok) begin
        for (int i = 0; i < NUM_COEF; i++) in_c[i] = get_coef(s_poly, i);
        err = (s_deg > s_tgt) || (s_tgt > NUM_COEF - 1);
        d = s_tgt - s_deg;
        exp_err = err;
        exp_shift = err ? 0 : d;
        exp_lead = (s_deg < NUM_COEF) ? in_c[s_deg] : '0;
        for (int i = 0; i < NUM_COEF; i++) begin
          if (err) exp_c[i] = in_c[i];
          else exp_c[i] = (i - d >= 0) ? in_c[i-d] : '0;
        end
        lat = err ? 1 : d + 1;
        pending = 1;
        done_edge = cyc + lat;
        next_ok = done_edge + 1;
      end
      exp_busy = pending && (cyc < done_edge);
      exp_done = pending && (cyc == done_edge);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("align_done", 32'(align_done), 32'(exp_done));
      if (!exp_busy) begin
        for (int i = 0; i < NUM_COEF; i++) chk("poly_out_coef", 32'(get_coef(poly_out, i)), 32'(exp_c[i]));
        chk("lead_coef_out", 32'(lead_coef_out), 32'(exp_lead));
        chk("shift_amt_out", 32'(shift_amt_out), 32'(exp_shift));
        chk("align_err", 32'(align_err), 32'(exp_err));
      end
      if (exp_done) pending = 0;
      cyc++;
    end
  end

  task automatic drive_random();
    for (int i = 0; i < NUM_COEF; i++) poly_in[i*COEF_W +: COEF_W] = COEF_W'($urandom);
    poly_deg_in = DEG_W'($urandom);
    target_deg  = DEG_W'($urandom);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NUM_COEF; i++) req_c[i] = COEF_W'($urandom);
  endtask

  task automatic issue(input int deg, input int tgt, input bit pulse_mid, output int lat);
    @(negedge clk);
    for (int i = 0; i < NUM_COEF; i++) poly_in[i*COEF_W +: COEF_W] = req_c[i];
    poly_deg_in = DEG_W'(deg);
    target_deg  = DEG_W'(tgt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_random();
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (pulse_mid) start = (n == 3);
      if (align_done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin : stim
    int lat, dones;
    int b2b_deg [4];
    int b2b_shift [4];
    b2b_deg = '{9, 7, 1, 0};
    b2b_shift = '{2, 4, 10, 11};

    repeat (5) begin
      @(negedge clk);
      drive_random();
      start = 1'($urandom);
    end
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_poly_out_nonzero", 32'(|poly_out), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_b = 1'b1;

    for (int i = 0; i < NUM_COEF; i++) req_c[i] = '0;
    req_c[1] = 12'h2F7;
    req_c[0] = 12'h801;
    issue(1, 4, 0, lat);
    chk("basic_latency", 32'(lat), 32'd4);
    chk("basic_coef4", 32'(get_coef(poly_out, 4)), 32'h2F7);
    chk("basic_coef3", 32'(get_coef(poly_out, 3)), 32'h801);
    for (int i = 0; i < NUM_COEF; i++)
      if (i != 3 && i != 4) chk("basic_coef_zero", 32'(get_coef(poly_out, i)), 32'd0);
    chk("basic_lead", 32'(lead_coef_out), 32'h2F7);
    chk("basic_shift", 32'(shift_amt_out), 32'd3);
    chk("basic_err", 32'(align_err), 32'd0);

    fill_random();
    issue(7, 7, 0, lat);
    chk("noshift_latency", 32'(lat), 32'd1);
    for (int i = 0; i < NUM_COEF; i++) chk("noshift_coef", 32'(get_coef(poly_out, i)), 32'(req_c[i]));
    chk("noshift_shift", 32'(shift_amt_out), 32'd0);
    chk("noshift_lead", 32'(lead_coef_out), 32'(req_c[7]));

    fill_random();
    issue(9, 5, 0, lat);
    chk("err_latency", 32'(lat), 32'd1);
    chk("err_flag", 32'(align_err), 32'd1);
    chk("err_shift", 32'(shift_amt_out), 32'd0);
    chk("err_lead", 32'(lead_coef_out), 32'(req_c[9]));
    for (int i = 0; i < NUM_COEF; i++) chk("err_coef", 32'(get_coef(poly_out, i)), 32'(req_c[i]));

    fill_random();
    issue(3, 12, 0, lat);
    chk("err_tgt12_flag", 32'(align_err), 32'd1);
    chk("err_tgt12_shift", 32'(shift_amt_out), 32'd0);

    for (int i = 0; i < NUM_COEF; i++) req_c[i] = '0;
    issue(0, 11, 1, lat);
    chk("zero_latency", 32'(lat), 32'd12);
    chk("zero_poly_nonzero", 32'(|poly_out), 32'd0);
    chk("zero_lead", 32'(lead_coef_out), 32'd0);
    chk("zero_shift", 32'(shift_amt_out), 32'd11);
    dones = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (align_done) dones++;
    end
    chk("zero_extra_done", 32'(dones), 32'd0);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NUM_COEF; i++)
        req_c[i] = (i < b2b_deg[k]) ? COEF_W'($urandom) : '0;
      req_c[b2b_deg[k]] = COEF_W'($urandom) | 12'h001;
      issue(b2b_deg[k], 11, 0, lat);
      chk("b2b_shift", 32'(shift_amt_out), 32'(b2b_shift[k]));
      chk("b2b_latency", 32'(lat), 32'(b2b_shift[k] + 1));
      chk("b2b_coef11", 32'(get_coef(poly_out, 11)), 32'(req_c[b2b_deg[k]]));
      chk("b2b_lead", 32'(lead_coef_out), 32'(req_c[b2b_deg[k]]));
    end

    fill_random();
    @(negedge clk);
    for (int i = 0; i < NUM_COEF; i++) poly_in[i*COEF_W +: COEF_W] = req_c[i];
    poly_deg_in = 4'd2;
    target_deg  = 4'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst_b = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(align_done), 32'd0);
    chk("midrst_poly_nonzero", 32'(|poly_out), 32'd0);
    chk("midrst_lead", 32'(lead_coef_out), 32'd0);
    chk("midrst_shift", 32'(shift_amt_out), 32'd0);
    chk("midrst_err", 32'(align_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    dones = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (align_done) dones++;
    end
    chk("midrst_no_resume", 32'(dones), 32'd0);

    for (int k = 0; k < 40; k++) begin
      int deg, tgt;
      fill_random();
      if ($urandom_range(0, 1) == 0) begin
        tgt = $urandom_range(0, 11);
        deg = $urandom_range(0, tgt);
      end else begin
        tgt = $urandom_range(0, 15);
        deg = $urandom_range(0, 15);
      end
      issue(deg, tgt, 0, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
